instr_cache_nway: RTL and testbench

//  Parametrised N-way set-associative instruction cache array with a built-in line-refill sequencer.

---
 rtl/instr_cache_nway.sv | 204 ++++++++++++++++++++
 tb/tb_instr_cache_nway.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_cache_nway.sv
// N-way set-associative instruction cache: combinational hit lookup, line refill over an
// AHB-style bus, tree pseudo-LRU replacement and a one-set-per-cycle invalidate sweep.
module instr_cache_nway #(
  parameter int WAYS  = 4,
  parameter int LINES = 64,
  parameter int BSIZE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [31:0] A,
  input  logic        Invalidate,
  input  logic [31:0] HRData,
  input  logic        HReady,
  output logic        Hit,
  output logic [31:0] RD,
  output logic        Stall,
  output logic        HRequest,
  output logic [31:0] HAddr,
  output logic        InvBusy
);
  localparam int SBITS  = $clog2(LINES);
  localparam int BOBITS = $clog2(BSIZE);
  localparam int TBITS  = 30 - SBITS - BOBITS;
  localparam int WBITS  = $clog2(WAYS);

  typedef enum logic [1:0] {IDLE, FILL, INVAL} state_t;
  state_t state, state_nxt;

  logic [TBITS-1:0] tag_mem  [WAYS][LINES];
  logic [31:0]      data_mem [WAYS][LINES][BSIZE];
  logic [WAYS-1:0]  valid    [LINES];
  // Heap-ordered PLRU tree: node n lives at bit n (1..WAYS-1), children 2n and 2n+1; bit 0 unused.
  logic [WAYS-1:0]  plru     [LINES];

  logic [TBITS-1:0]  fill_tag;
  logic [SBITS-1:0]  fill_set;
  logic [SBITS-1:0]  inv_cnt;
  logic [BOBITS-1:0] beat;
  logic [WBITS-1:0]  victim;
  logic              pend;

  logic [TBITS-1:0]  a_tag;
  logic [SBITS-1:0]  a_set;
  logic [BOBITS-1:0] a_word;
  logic              a_unused;
  logic [WAYS-1:0]   match;
  logic              any_match;
  logic [WBITS-1:0]  hit_way;
  logic [WBITS-1:0]  vic_way;
  logic [31:0]       hit_dat;
  logic              last_beat;
  logic              inv_done;

  assign a_tag    = A[31:32-TBITS];
  assign a_set    = A[SBITS+BOBITS+1:BOBITS+2];
  assign a_word   = A[BOBITS+1:2];
  assign a_unused = ^A[1:0];

  function automatic logic [WBITS-1:0] plru_pick(input logic [WAYS-1:0] t);
    logic [WBITS:0] node;
    node    = '0;
    node[0] = 1'b1;
    for (int l = 0; l < WBITS; l++)
      node = {node[WBITS-1:0], t[node[WBITS-1:0]]};
    return node[WBITS-1:0];
  endfunction

  function automatic logic [WAYS-1:0] plru_touch(input logic [WAYS-1:0] t,
                                                 input logic [WBITS-1:0] w);
    logic [WAYS-1:0]  r;
    logic [WBITS:0]   node;
    logic [WBITS-1:0] path;
    r       = t;
    node    = '0;
    node[0] = 1'b1;
    path    = w;
    for (int l = 0; l < WBITS; l++) begin
      r[node[WBITS-1:0]] = ~path[WBITS-1];
      node = {node[WBITS-1:0], path[WBITS-1]};
      path = path << 1;
    end
    return r;
  endfunction

  // Lookup and victim choice; descending loops leave the lowest matching / invalid way selected.
  always_comb begin
    match   = '0;
    hit_way = '0;
    hit_dat = '0;
    vic_way = plru_pick(plru[a_set]);
    for (int i = 0; i < WAYS; i++)
      match[i] = valid[a_set][i] && (tag_mem[i][a_set] == a_tag);
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_way = WBITS'(i);
        hit_dat = data_mem[i][a_set][a_word];
      end
      if (!valid[a_set][i])
        vic_way = WBITS'(i);
    end
  end

  assign any_match = |match;
  assign last_beat = (state == FILL) && HReady && (beat == BOBITS'(BSIZE - 1));
  assign inv_done  = (inv_cnt == SBITS'(LINES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Invalidate)        state_nxt = INVAL;
               else if (Req && !Hit)  state_nxt = FILL;
      FILL:    if (last_beat)         state_nxt = (pend || Invalidate) ? INVAL : IDLE;
      INVAL:   if (inv_done)          state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Hit      = 1'b0;
    RD       = '0;
    Stall    = 1'b1;
    HRequest = 1'b0;
    HAddr    = '0;
    InvBusy  = pend;
    case (state)
      IDLE: begin
        Hit   = Req && any_match;
        RD    = Hit ? hit_dat : '0;
        Stall = Req && !any_match;
      end
      FILL: begin
        HRequest = 1'b1;
        HAddr    = {fill_tag, fill_set, beat, 2'b00};
      end
      INVAL:   InvBusy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < LINES; s++) begin
        valid[s] <= '0;
        plru[s]  <= '0;
      end
      fill_tag <= '0;
      fill_set <= '0;
      victim   <= '0;
      beat     <= '0;
      inv_cnt  <= '0;
      pend     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Hit)
            plru[a_set] <= plru_touch(plru[a_set], hit_way);
          if (Invalidate)
            inv_cnt <= '0;
          else if (Req && !Hit) begin
            fill_tag <= a_tag;
            fill_set <= a_set;
            victim   <= vic_way;
            beat     <= '0;
          end
        end
        FILL: begin
          if (Invalidate) pend <= 1'b1;
          if (HReady)     beat <= beat + 1'b1;
          if (last_beat) begin
            valid[fill_set][victim] <= 1'b1;
            plru[fill_set]          <= plru_touch(plru[fill_set], victim);
            inv_cnt                 <= '0;
          end
        end
        INVAL: begin
          valid[inv_cnt] <= '0;
          plru[inv_cnt]  <= '0;
          inv_cnt        <= inv_cnt + 1'b1;
          if (inv_done) pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Line storage is not reset; valid bits alone gate its use.
  always_ff @(posedge clk) begin
    if (state == FILL && HReady) begin
      data_mem[victim][fill_set][beat] <= HRData;
      if (last_beat)
        tag_mem[victim][fill_set] <= fill_tag;
    end
  end

  a_single_hit: assert property (@(posedge clk) disable iff (!reset)
                                 (state == IDLE && Req) |-> $onehot0(match));

endmodule

// File: tb/tb_instr_cache_nway.sv
// Self-checking bench for instr_cache_nway: refill, PLRU victim choice, bus hold,
// invalidate during fill, and reset mid-fill.
module tb_instr_cache_nway;
  logic        clk = 1'b0;
  logic        reset, Req, Invalidate, HReady;
  logic [31:0] A, HRData;
  logic        Hit, Stall, HRequest, InvBusy;
  logic [31:0] RD, HAddr;

  int checks   = 0;
  int failures = 0;

  logic [31:0] addr_q [$];
  logic [32:0] rd_q   [$];

  typedef struct {
    logic [31:0] a;
    logic        hit;
    logic [31:0] rd;
  } vec_t;
  vec_t vt [20];

  always #5 clk = ~clk;

  instr_cache_nway #(.WAYS(4), .LINES(64), .BSIZE(4)) dut (
    .clk(clk), .reset(reset), .Req(Req), .A(A), .Invalidate(Invalidate),
    .HRData(HRData), .HReady(HReady), .Hit(Hit), .RD(RD), .Stall(Stall),
    .HRequest(HRequest), .HAddr(HAddr), .InvBusy(InvBusy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Fetch lookup; Req is held through the edge only for expected hits so PLRU is touched.
  task automatic rd(input string nm, input logic [31:0] a, input logic eh, input logic [31:0] ed);
    logic [32:0] e;
    Req = 1'b1;
    A   = a;
    rd_q.push_back({eh, eh ? ed : 32'h0});
    #1;
    e = rd_q.pop_front();
    chkb({nm, "_hit"}, Hit, e[32]);
    chk({nm, "_rd"}, RD, e[31:0]);
    if (!eh) Req = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_fill(input logic [31:0] a, input logic [31:0] d0,
                         input int hold_beat, input int hold_n, input int inv_beat);
    int          beat  = 0;
    int          cyc   = 0;
    int          holds = hold_n;
    logic [31:0] line;
    line = {a[31:4], 4'h0};
    Req  = 1'b1;
    A    = a;
    #1;
    chkb("miss_hit", Hit, 1'b0);
    chkb("miss_stall", Stall, 1'b1);
    for (int b = 0; b < 4; b++) addr_q.push_back(line + 32'(b * 4));
    @(negedge clk);
    A = ~a;
    while (addr_q.size() > 0 && cyc < 40) begin
      cyc++;
      #1;
      chkb("fill_hreq", HRequest, 1'b1);
      chk("fill_haddr", HAddr, addr_q[0]);
      if (inv_beat >= 0 && beat > inv_beat) chkb("fill_invbusy", InvBusy, 1'b1);
      Invalidate = (beat == inv_beat);
      if (beat == hold_beat && holds > 0) begin
        HReady = 1'b0;
        HRData = 32'hDEADBEEF;
        holds--;
      end else begin
        HReady = 1'b1;
        HRData = d0 + 32'(beat);
        void'(addr_q.pop_front());
        beat++;
      end
      @(negedge clk);
    end
    HReady     = 1'b0;
    Invalidate = 1'b0;
    A          = a;
    chk("fill_cycles", cyc, 32'(4 + hold_n));
    addr_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    reset = 1'b0; Req = 1'b0; A = '0; Invalidate = 1'b0; HRData = '0; HReady = 1'b0;

    vt[0]  = '{32'h0000, 1'b0, 32'h0};
    vt[1]  = '{32'h0404, 1'b1, 32'h201};
    vt[2]  = '{32'h0808, 1'b1, 32'h302};
    vt[3]  = '{32'h0C0C, 1'b1, 32'h403};
    vt[4]  = '{32'h1004, 1'b1, 32'h501};
    vt[5]  = '{32'h0104, 1'b1, 32'hA1};
    vt[6]  = '{32'h0014, 1'b1, 32'h901};
    vt[7]  = '{32'h0810, 1'b0, 32'h0};
    vt[8]  = '{32'h0418, 1'b1, 32'h912};
    vt[9]  = '{32'h0C1C, 1'b1, 32'h933};
    vt[10] = '{32'h101C, 1'b1, 32'h943};
    vt[11] = '{32'h2020, 1'b1, 32'h600};
    vt[12] = '{32'h2024, 1'b1, 32'h601};
    vt[13] = '{32'h2028, 1'b1, 32'h602};
    vt[14] = '{32'h202C, 1'b1, 32'h603};
    vt[15] = '{32'h0104, 1'b0, 32'h0};
    vt[16] = '{32'h0404, 1'b0, 32'h0};
    vt[17] = '{32'h0014, 1'b0, 32'h0};
    vt[18] = '{32'h2020, 1'b0, 32'h0};
    vt[19] = '{32'h3030, 1'b0, 32'h0};

    // Reset state
    @(negedge clk); #1;
    chkb("rst_hit", Hit, 1'b0);
    chk("rst_rd", RD, 32'h0);
    chkb("rst_stall", Stall, 1'b0);
    chkb("rst_hreq", HRequest, 1'b0);
    chk("rst_haddr", HAddr, 32'h0);
    chkb("rst_invbusy", InvBusy, 1'b0);
    Req = 1'b1; #1;
    chkb("rst_stall_req", Stall, 1'b1);
    Req = 1'b0;
    @(negedge clk); reset = 1'b1; @(negedge clk);

    // Basic refill then hit after the bubble
    do_fill(32'h104, 32'hA0, -1, 0, -1);
    rd("refill", 32'h104, 1'b1, 32'hA1);

    // Set 0: fill four ways, fifth miss evicts way 0
    do_fill(32'h0000, 32'h100, -1, 0, -1);
    do_fill(32'h0400, 32'h200, -1, 0, -1);
    do_fill(32'h0800, 32'h300, -1, 0, -1);
    do_fill(32'h0C00, 32'h400, -1, 0, -1);
    do_fill(32'h1000, 32'h500, -1, 0, -1);
    for (int i = 0; i < 6; i++) rd($sformatf("vecA%0d", i), vt[i].a, vt[i].hit, vt[i].rd);

    // Set 1: hit way 0 before the fifth miss, PLRU then evicts way 2
    do_fill(32'h0010, 32'h900, -1, 0, -1);
    do_fill(32'h0410, 32'h910, -1, 0, -1);
    do_fill(32'h0810, 32'h920, -1, 0, -1);
    do_fill(32'h0C10, 32'h930, -1, 0, -1);
    rd("plru_touch", 32'h0010, 1'b1, 32'h900);
    do_fill(32'h1010, 32'h940, -1, 0, -1);
    for (int i = 6; i < 11; i++) rd($sformatf("vecB%0d", i), vt[i].a, vt[i].hit, vt[i].rd);

    // Bus holds HReady low for 3 cycles before beat 2
    do_fill(32'h2020, 32'h600, 2, 3, -1);
    for (int i = 11; i < 15; i++) rd($sformatf("vecC%0d", i), vt[i].a, vt[i].hit, vt[i].rd);

    // Invalidate arrives during the fill; fill completes, then the sweep runs
    do_fill(32'h3030, 32'h700, -1, 0, 1);
    n = 0; bad = 0;
    Req = 1'b1; A = 32'h3030;
    while (n < 200) begin
      #1;
      if (!InvBusy) break;
      if (Hit || !Stall) bad++;
      n++;
      @(negedge clk);
    end
    chk("inval_cycles", n, 32'd64);
    chk("inval_hit_stall", bad, 32'd0);
    chkb("post_inval_hit", Hit, 1'b0);
    Req = 1'b0;
    @(negedge clk);
    for (int i = 15; i < 20; i++) rd($sformatf("vecD%0d", i), vt[i].a, vt[i].hit, vt[i].rd);

    // Reset asserted at beat 2 of a fill
    Req = 1'b1; A = 32'h4040; #1;
    chkb("rfill_miss", Hit, 1'b0);
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      HReady = 1'b1; HRData = 32'hBAD0 + 32'(b);
      @(negedge clk);
    end
    HReady = 1'b0; #1;
    chk("rfill_haddr_b2", HAddr, 32'h4048);
    reset = 1'b0; #1;
    chkb("rfill_hreq", HRequest, 1'b0);
    chk("rfill_haddr", HAddr, 32'h0);
    chkb("rfill_stall", Stall, 1'b1);
    Req = 1'b0;
    @(negedge clk); reset = 1'b1; @(negedge clk);
    rd("rfill_line", 32'h4048, 1'b0, 32'h0);
    do_fill(32'h4040, 32'h800, -1, 0, -1);
    rd("rfill_refill", 32'h4048, 1'b1, 32'h802);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
